instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 4'h0, the address the unit sends to the program counter after reset.
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-004 SHALL have port pc_addr, input, 4, the current program counter value.
REQ-005 SHALL have port zero_flag, input, 1, the ALU zero status.
REQ-006 SHALL have port carry_flag, input, 1, the ALU carry status.
REQ-007 SHALL have port resume, input, 1, a pulse that leaves HALT.
REQ-008 SHALL have port prog_we, input, 1, the program memory write enable.
REQ-009 SHALL have port prog_addr, input, 4, the program memory write address.
REQ-010 SHALL have port prog_data, input, 8, the program memory write data.
REQ-011 SHALL have port pc_inc, output, 1, a one-cycle increment strobe to the program counter.
REQ-012 SHALL have port jump, output, 1, a one-cycle load strobe to the program counter.
REQ-013 SHALL have port jump_addr, output, 4, the load value for the program counter.
REQ-014 SHALL have port opcode, output, 4, the decoded instruction field ir[7:4].
REQ-015 SHALL have port operand, output, 4, the decoded instruction field ir[3:0].
REQ-016 SHALL have port instr_valid, output, 1, asserted for one cycle while opcode and operand are valid.
REQ-017 SHALL have port halted, output, 1, high while the unit is in HALT.

Function
REQ-018 SHALL contain a 16x8 program memory and an 8-bit instruction register (ir).
REQ-019 SHALL write prog_data to mem[prog_addr] on any clk edge with prog_we=1, in any state, including during rst.
REQ-020 SHALL implement the states BOOT, FETCH, DECODE, EXEC and HALT, with every output driven directly from flops.
REQ-021 BOOT: SHALL assert jump=1 with jump_addr=RESET_VECTOR for one cycle, then go to FETCH.
REQ-022 FETCH: SHALL load ir from mem[pc_addr], then go to DECODE.
REQ-023 FETCH with prog_we=1 and prog_addr==pc_addr: ir SHALL take prog_data (write-first).
REQ-024 DECODE: SHALL drive opcode=ir[7:4] and operand=ir[3:0] and assert instr_valid=1 for exactly one cycle, then go to EXEC.
REQ-025 EXEC with opcode 4'hE (JMP): SHALL assert jump=1 with jump_addr=operand, then go to FETCH.
REQ-026 EXEC with 4'hC (JZ) or 4'hD (JC): SHALL jump when the sampled flag is 1 and otherwise assert pc_inc=1; the flag is sampled during the EXEC cycle.
REQ-027 EXEC with 4'hF (HLT): SHALL assert neither pc_inc nor jump and SHALL go to HALT.
REQ-028 EXEC with any other opcode, including 4'h0 NOP: SHALL assert pc_inc=1 and go to FETCH.
REQ-029 HALT: SHALL hold halted=1. When resume=1 it SHALL assert pc_inc=1 for one cycle and go to FETCH.
REQ-030 SHALL never assert jump and pc_inc in the same cycle.
REQ-031 Each instruction SHALL take 3 cycles (FETCH, DECODE, EXEC).
REQ-032 Address 4'hF followed by pc_inc SHALL wrap to 4'h0, since the wrap is owned by the program counter; no special handling.
REQ-033 jump_addr SHALL hold its last value when jump=0.

Reset
REQ-034 While rst=1: state=BOOT, ir=8'h00, pc_inc=0, jump=0, jump_addr=RESET_VECTOR, opcode=0, operand=0, instr_valid=0, halted=0.
REQ-035 rst SHALL override resume and every in-flight state, including mid-EXEC and HALT.
REQ-036 Program memory contents SHALL NOT be reset.
REQ-037 The first cycle after rst deasserts SHALL be BOOT, so jump=1 appears one cycle after rst falls.

Configuration
REQ-038 Macro INSTR_FETCH_COND_JUMP_EN SHALL control conditional jumps.
REQ-039 Defined: JZ and JC SHALL behave per REQ-026.
REQ-040 Undefined: 4'hC and 4'hD SHALL be treated as NOP (pc_inc=1), and zero_flag and carry_flag SHALL be ignored.

Verification
REQ-041 Bench SHALL cover boot: rst high for 2 cycles, then low -> jump=1 with jump_addr=4'h0 on the 1st cycle after release, then FETCH.
REQ-042 Bench SHALL cover sequential NOPs: mem[0..2]=8'h00, pc_addr stepped by the model -> pc_inc pulse every 3rd cycle, instr_valid precedes each pulse by 1 cycle.
REQ-043 Bench SHALL cover JMP: mem[1]=8'hE9, pc_addr=1 -> jump=1 with jump_addr=4'h9 in EXEC, and pc_inc=0 throughout.
REQ-044 Bench SHALL cover conditional jump: mem[2]=8'hC5; with zero_flag=1 -> jump with jump_addr=5; with zero_flag=0 -> pc_inc=1. With the macro undefined -> pc_inc=1 in both cases.
REQ-045 Bench SHALL cover halt/resume: mem[3]=8'hF0 -> halted=1 and no strobes for 10 cycles. resume=1 -> pc_inc=1 on the next cycle and halted=0. resume and rst together -> BOOT.
REQ-046 Bench SHALL cover write-first: in FETCH with pc_addr=4, prog_we=1, prog_addr=4, prog_data=8'hE7 -> operand=7 and jump_addr=7.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch/decode/exec sequencer with a 16x8 program memory
// Optional feature: define INSTR_FETCH_COND_JUMP_EN to enable JZ (4'hC) and JC (4'hD);
// without it those opcodes behave as NOP and the ALU flags are ignored.
module instruction_fetch_unit #(
    parameter logic [3:0] RESET_VECTOR = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] pc_addr,
    input  logic       zero_flag,
    input  logic       carry_flag,
    input  logic       resume,
    input  logic       prog_we,
    input  logic [3:0] prog_addr,
    input  logic [7:0] prog_data,
    output logic       pc_inc,
    output logic       jump,
    output logic [3:0] jump_addr,
    output logic [3:0] opcode,
    output logic [3:0] operand,
    output logic       instr_valid,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_BOOT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_JZ  = 4'hC;
    localparam logic [3:0] OP_JC  = 4'hD;
    localparam logic [3:0] OP_JMP = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Program memory is deliberately never reset.
    logic [7:0] mem_q [16];

    state_t     state_q;
    logic [7:0] ir_q;
    logic [7:0] ir_d;
    logic       pc_inc_q;
    logic       jump_q;
    logic [3:0] jump_addr_q;
    logic [3:0] opcode_q;
    logic [3:0] operand_q;
    logic       instr_valid_q;
    logic       halted_q;

    logic       exec_jump;
    logic       exec_halt;

    // Program loads are accepted on every edge, whatever the FSM is doing, even in reset.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    // A write landing on the word being fetched is forwarded so the fresh value is executed.
    always_comb begin
        ir_d = mem_q[pc_addr];
        if (prog_we && (prog_addr == pc_addr)) begin
            ir_d = prog_data;
        end
    end

    // Classify the instruction held in ir; flags are read live so they are sampled in EXEC.
    always_comb begin
        exec_jump = 1'b0;
        exec_halt = 1'b0;
        case (ir_q[7:4])
            OP_JMP:  exec_jump = 1'b1;
            OP_HLT:  exec_halt = 1'b1;
`ifdef INSTR_FETCH_COND_JUMP_EN
            OP_JZ:   exec_jump = zero_flag;
            OP_JC:   exec_jump = carry_flag;
`endif
            default: begin
                exec_jump = 1'b0;
                exec_halt = 1'b0;
            end
        endcase
    end

`ifndef INSTR_FETCH_COND_JUMP_EN
    // Flags have no consumer when conditional jumps are compiled out.
    logic unused_flags;
    assign unused_flags = zero_flag | carry_flag;
`endif

    // Sequencer: state plus every output is registered; strobes self-clear after one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_BOOT;
            ir_q          <= 8'h00;
            pc_inc_q      <= 1'b0;
            jump_q        <= 1'b0;
            jump_addr_q   <= RESET_VECTOR;
            opcode_q      <= 4'h0;
            operand_q     <= 4'h0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            pc_inc_q      <= 1'b0;
            jump_q        <= 1'b0;
            instr_valid_q <= 1'b0;
            case (state_q)
                S_BOOT: begin
                    jump_q      <= 1'b1;
                    jump_addr_q <= RESET_VECTOR;
                    state_q     <= S_FETCH;
                end
                S_FETCH: begin
                    ir_q    <= ir_d;
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    opcode_q      <= ir_q[7:4];
                    operand_q     <= ir_q[3:0];
                    instr_valid_q <= 1'b1;
                    state_q       <= S_EXEC;
                end
                S_EXEC: begin
                    if (exec_halt) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else if (exec_jump) begin
                        jump_q      <= 1'b1;
                        jump_addr_q <= ir_q[3:0];
                        state_q     <= S_FETCH;
                    end else begin
                        pc_inc_q <= 1'b1;
                        state_q  <= S_FETCH;
                    end
                end
                S_HALT: begin
                    if (resume) begin
                        halted_q <= 1'b0;
                        pc_inc_q <= 1'b1;
                        state_q  <= S_FETCH;
                    end
                end
                default: begin
                    state_q <= S_BOOT;
                end
            endcase
        end
    end

    assign pc_inc      = pc_inc_q;
    assign jump        = jump_q;
    assign jump_addr   = jump_addr_q;
    assign opcode      = opcode_q;
    assign operand     = operand_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    localparam logic [3:0] RV = 4'h0;
`ifdef INSTR_FETCH_COND_JUMP_EN
    localparam bit CJ = 1'b1;
`else
    localparam bit CJ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] pc_addr;
    logic       zero_flag;
    logic       carry_flag;
    logic       resume;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic       pc_inc;
    logic       jump;
    logic [3:0] jump_addr;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic       instr_valid;
    logic       halted;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_VECTOR(RV)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_addr     (pc_addr),
        .zero_flag   (zero_flag),
        .carry_flag  (carry_flag),
        .resume      (resume),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .pc_inc      (pc_inc),
        .jump        (jump),
        .jump_addr   (jump_addr),
        .opcode      (opcode),
        .operand     (operand),
        .instr_valid (instr_valid),
        .halted      (halted)
    );

    typedef struct {
        logic [3:0] pc;
        logic [7:0] ins;
        logic       zf;
        logic       cf;
        logic       exp_inc;
        logic       exp_jump;
        logic [3:0] exp_ja;
    } vec_t;

    vec_t       tbl [11];
    int         tests = 0;
    int         fails = 0;
    logic [7:0] mm [16];
    logic [3:0] pc;
    logic [3:0] ja_m;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // {pc_inc, jump, jump_addr, instr_valid, halted}
    function automatic logic [7:0] outs();
        return {pc_inc, jump, jump_addr, instr_valid, halted};
    endfunction

    // Instruction-level reference: what the EXEC step must do for this word and these flags.
    task automatic ref_exec(input logic [7:0] ins, input logic zf, input logic cf,
                            output logic inc, output logic jmp, output logic hlt,
                            output logic [3:0] tgt);
        logic [3:0] op;
        op  = ins[7:4];
        inc = 1'b0;
        jmp = 1'b0;
        hlt = 1'b0;
        tgt = ins[3:0];
        if (op == 4'hF)
            hlt = 1'b1;
        else if (op == 4'hE)
            jmp = 1'b1;
        else if (CJ && ((op == 4'hC && zf) || (op == 4'hD && cf)))
            jmp = 1'b1;
        else
            inc = 1'b1;
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        prog_addr = a;
        prog_data = d;
        prog_we   = 1'b1;
        step();
        prog_we   = 1'b0;
        mm[a]     = d;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        resume = 1'b0;
        step();
        step();
        chk("reset_outs", outs(), {1'b0, 1'b0, RV, 1'b0, 1'b0});
        chk("reset_fields", {opcode, operand}, 8'h00);
        ja_m = RV;
    endtask

    task automatic release_boot();
        rst = 1'b0;
        step();
        chk("boot_jump", outs(), {1'b0, 1'b1, RV, 1'b0, 1'b0});
        ja_m    = RV;
        pc      = RV;
        pc_addr = pc;
    endtask

    // Runs one instruction from the current FETCH cycle; leaves bench in the next FETCH/HALT cycle.
    task automatic run_instr(input string tag, input logic [3:0] a, input logic zf,
                             input logic cf, output logic hlt);
        logic inc;
        logic jmp;
        logic [3:0] tgt;
        pc_addr    = a;
        zero_flag  = ~zf;
        carry_flag = ~cf;
        step();
        chk({tag, "_decode"}, outs(), {1'b0, 1'b0, ja_m, 1'b0, 1'b0});
        zero_flag  = zf;
        carry_flag = cf;
        step();
        chk({tag, "_exec"}, {instr_valid, opcode, operand}, {1'b1, mm[a]});
        ref_exec(mm[a], zf, cf, inc, jmp, hlt, tgt);
        step();
        if (jmp) ja_m = tgt;
        chk({tag, "_strobe"}, outs(), {inc, jmp, ja_m, 1'b0, hlt});
        pc      = jmp ? tgt : (inc ? a + 4'd1 : a);
        pc_addr = pc;
    endtask

    initial begin
        logic h;
        rst = 1'b1; pc_addr = 4'h0; zero_flag = 1'b0; carry_flag = 1'b0;
        resume = 1'b0; prog_we = 1'b0; prog_addr = 4'h0; prog_data = 8'h00;
        pc = 4'h0; ja_m = RV;

        // Phase 1: boot, sequential NOPs, halt/resume, rst+resume
        do_reset();
        load(4'h0, 8'h00);
        load(4'h1, 8'h00);
        load(4'h2, 8'h00);
        load(4'h3, 8'hF0);
        release_boot();
        for (int i = 1; i <= 11; i++) begin
            logic e_inc;
            logic e_iv;
            step();
            e_iv  = (i % 3 == 2);
            e_inc = (i % 3 == 0);
            chk($sformatf("nop_cyc%0d", i), outs(), {e_inc, 1'b0, RV, e_iv, 1'b0});
            if (e_inc) begin
                pc      = pc + 4'd1;
                pc_addr = pc;
            end
        end
        for (int i = 0; i < 10; i++) begin
            zero_flag  = 1'($urandom);
            carry_flag = 1'($urandom);
            step();
            chk($sformatf("halt_hold%0d", i), outs(), {1'b0, 1'b0, RV, 1'b0, 1'b1});
        end
        resume = 1'b1;
        step();
        resume = 1'b0;
        chk("resume_inc", outs(), {1'b1, 1'b0, RV, 1'b0, 1'b0});
        pc_addr = 4'h3;
        step();
        step();
        step();
        chk("halt_again", outs(), {1'b0, 1'b0, RV, 1'b0, 1'b1});
        rst    = 1'b1;
        resume = 1'b1;
        step();
        chk("rst_resume", outs(), {1'b0, 1'b0, RV, 1'b0, 1'b0});
        rst    = 1'b0;
        resume = 1'b0;
        step();
        chk("rst_resume_boot", outs(), {1'b0, 1'b1, RV, 1'b0, 1'b0});

        // Phase 2: table of single instructions, then write-first forwarding
        tbl[0]  = '{4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0};
        tbl[1]  = '{4'h1, 8'hE9, 1'b0, 1'b0, 1'b0, 1'b1, 4'h9};
        tbl[2]  = '{4'h2, 8'hC5, 1'b1, 1'b0, !CJ, CJ, CJ ? 4'h5 : 4'h9};
        tbl[3]  = '{4'h2, 8'hC5, 1'b0, 1'b1, 1'b1, 1'b0, CJ ? 4'h5 : 4'h9};
        tbl[4]  = '{4'h5, 8'hD3, 1'b0, 1'b1, !CJ, CJ, CJ ? 4'h3 : 4'h9};
        tbl[5]  = '{4'h5, 8'hD3, 1'b1, 1'b0, 1'b1, 1'b0, CJ ? 4'h3 : 4'h9};
        tbl[6]  = '{4'h7, 8'h3A, 1'b1, 1'b1, 1'b1, 1'b0, CJ ? 4'h3 : 4'h9};
        tbl[7]  = '{4'h6, 8'hE0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0};
        tbl[8]  = '{4'hF, 8'h12, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0};
        tbl[9]  = '{4'h8, 8'hDB, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0};
        tbl[10] = '{4'h9, 8'hC0, 1'b1, 1'b1, !CJ, CJ, 4'h0};
        do_reset();
        for (int i = 0; i < 16; i++) load(4'(i), 8'h00);
        foreach (tbl[i]) load(tbl[i].pc, tbl[i].ins);
        release_boot();
        foreach (tbl[i]) begin
            pc_addr    = tbl[i].pc;
            zero_flag  = ~tbl[i].zf;
            carry_flag = ~tbl[i].cf;
            step();
            chk($sformatf("tbl%0d_decode", i), {instr_valid, pc_inc, jump}, 3'b000);
            zero_flag  = tbl[i].zf;
            carry_flag = tbl[i].cf;
            step();
            chk($sformatf("tbl%0d_exec", i), {instr_valid, opcode, operand}, {1'b1, tbl[i].ins});
            step();
            chk($sformatf("tbl%0d_strobe", i), outs(),
                {tbl[i].exp_inc, tbl[i].exp_jump, tbl[i].exp_ja, 1'b0, 1'b0});
        end
        pc_addr   = 4'h4;
        prog_we   = 1'b1;
        prog_addr = 4'h4;
        prog_data = 8'hE7;
        step();
        prog_we   = 1'b0;
        mm[4]     = 8'hE7;
        chk("wf_decode", {instr_valid, pc_inc, jump}, 3'b000);
        step();
        chk("wf_exec", {instr_valid, opcode, operand}, {1'b1, 8'hE7});
        step();
        chk("wf_strobe", outs(), {1'b0, 1'b1, 4'h7, 1'b0, 1'b0});
        ja_m = 4'h7;
        run_instr("wf_stored", 4'h4, 1'b0, 1'b0, h);

        // Phase 3: random programs against the instruction-level reference
        do_reset();
        for (int i = 0; i < 16; i++) load(4'(i), 8'($urandom));
        release_boot();
        for (int n = 0; n < 150; n++) begin
            run_instr($sformatf("rnd%0d", n), pc, 1'($urandom), 1'($urandom), h);
            if (h) begin
                int k;
                k = $urandom_range(1, 4);
                for (int j = 0; j < k; j++) begin
                    zero_flag  = 1'($urandom);
                    carry_flag = 1'($urandom);
                    step();
                    chk($sformatf("rnd%0d_halt", n), outs(), {1'b0, 1'b0, ja_m, 1'b0, 1'b1});
                end
                resume = 1'b1;
                step();
                resume = 1'b0;
                chk($sformatf("rnd%0d_resume", n), outs(), {1'b1, 1'b0, ja_m, 1'b0, 1'b0});
                pc      = pc + 4'd1;
                pc_addr = pc;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
